// File: rtl/aurora_nfc_pkg.sv
// rtl/aurora_nfc_pkg.sv - NFC message field layout and responder state, shared with nfc_gen
package aurora_nfc_pkg;

  localparam int NFC_MSG_W    = 16;
  localparam int NFC_XOFF_BIT = 15;
  localparam int NFC_CNT_W    = 8;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    PAUSE = 2'd1,
    XOFF  = 2'd2
  } nfc_state_t;

endpackage

// File: rtl/axis_skid_slice.sv
// rtl/axis_skid_slice.sv - registered stream slice with 2-entry skid; enable gates admit and drain
module axis_skid_slice #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data
);

  logic [DATA_W-1:0] skid_mem [2];
  logic [1:0]        skid_cnt;
  logic              skid_rd;
  logic              skid_wr;
  logic              push;
  logic              pop;
  logic              out_free;
  logic              load_skid;
  logic              load_in;
  logic              skid_push;

  // s_ready only looks at registered state, so m_ready never reaches it
  assign s_ready   = enable & (skid_cnt != 2'd2);
  assign push      = s_valid & s_ready;
  assign pop       = m_valid & m_ready;
  assign out_free  = ~m_valid | pop;
  assign load_skid = enable & out_free & (skid_cnt != 2'd0);
  assign load_in   = push & out_free & (skid_cnt == 2'd0);
  assign skid_push = push & ~load_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid  <= 1'b0;
      m_data   <= '0;
      skid_cnt <= 2'd0;
      skid_rd  <= 1'b0;
      skid_wr  <= 1'b0;
    end else begin
      if (load_skid) begin
        m_valid <= 1'b1;
        m_data  <= skid_mem[skid_rd];
      end else if (load_in) begin
        m_valid <= 1'b1;
        m_data  <= s_data;
      end else if (pop) begin
        m_valid <= 1'b0;
      end
      if (skid_push) skid_wr <= ~skid_wr;
      if (load_skid) skid_rd <= ~skid_rd;
      skid_cnt <= skid_cnt + {1'b0, skid_push} - {1'b0, load_skid};
    end
  end

  always_ff @(posedge clk) begin
    if (skid_push) skid_mem[skid_wr] <= s_data;
  end

endmodule

// File: rtl/nfc_tx_pause.sv
// rtl/nfc_tx_pause.sv - NFC responder: decodes pause/XOFF/XON and gates the TX stream at beat boundaries
module nfc_tx_pause
  import aurora_nfc_pkg::*;
#(
  parameter int DATA_W   = 64,
  parameter int CNT_W    = NFC_CNT_W,
  parameter int XOFF_BIT = NFC_XOFF_BIT,
  parameter int STAT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 nfc_valid,
  output logic                 nfc_ready,
  input  logic [NFC_MSG_W-1:0] nfc_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [DATA_W-1:0]    s_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [DATA_W-1:0]    m_data,
  output logic                 paused,
  output logic [STAT_W-1:0]    stall_cycles
);

  nfc_state_t       state;
  nfc_state_t       state_n;
  logic [CNT_W-1:0] pause_cnt;
  logic [CNT_W-1:0] pause_cnt_n;
  logic             live;
  logic             nfc_fire;
  logic [CNT_W-1:0] nfc_cnt;
  logic             unused_nfc_bits;

  // live holds both ready outputs low until the first edge out of reset
  assign nfc_ready       = live;
  assign nfc_fire        = nfc_valid & live;
  assign nfc_cnt         = nfc_data[CNT_W-1:0];
  assign paused          = (state != RUN);
  assign unused_nfc_bits = ^nfc_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live         <= 1'b0;
      state        <= RUN;
      pause_cnt    <= '0;
      stall_cycles <= '0;
    end else begin
      live      <= 1'b1;
      state     <= state_n;
      pause_cnt <= pause_cnt_n;
      if (paused && (stall_cycles != {STAT_W{1'b1}}))
        stall_cycles <= stall_cycles + STAT_W'(1);
    end
  end

  // A freshly accepted message overrides the running countdown; counts never accumulate
  always_comb begin
    state_n     = state;
    pause_cnt_n = pause_cnt;
    if (state == PAUSE) begin
      pause_cnt_n = pause_cnt - CNT_W'(1);
      if (pause_cnt == CNT_W'(1)) state_n = RUN;
    end
    if (nfc_fire) begin
      if (nfc_data[XOFF_BIT]) begin
        state_n     = XOFF;
        pause_cnt_n = '0;
      end else if (nfc_cnt == '0) begin
        state_n     = RUN;
        pause_cnt_n = '0;
      end else begin
        state_n     = PAUSE;
        pause_cnt_n = nfc_cnt;
      end
    end
  end

  axis_skid_slice #(
    .DATA_W (DATA_W)
  ) u_slice (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable  (live & (state == RUN)),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data)
  );

endmodule

// File: tb/tb_nfc_tx_pause.sv
// tb/tb_nfc_tx_pause.sv - self-checking bench for nfc_tx_pause
module tb_nfc_tx_pause;

  localparam int TB_STAT_W = 10;
  localparam int STAT_MAX  = (1 << TB_STAT_W) - 1;
  localparam int LEN_BOUND = 300;

  logic                 clk;
  logic                 rst_n;
  logic                 nfc_valid;
  logic                 nfc_ready;
  logic [15:0]          nfc_data;
  logic                 s_valid;
  logic                 s_ready;
  logic [63:0]          s_data;
  logic                 m_valid;
  logic                 m_ready;
  logic [63:0]          m_data;
  logic                 paused;
  logic [TB_STAT_W-1:0] stall_cycles;

  nfc_tx_pause #(.DATA_W(64), .STAT_W(TB_STAT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .nfc_valid    (nfc_valid),
    .nfc_ready    (nfc_ready),
    .nfc_data     (nfc_data),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .paused       (paused),
    .stall_cycles (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // reference model: pause as remaining cycles plus an xoff flag
  int          m_pause_left;
  bit          m_xoff;
  int          m_stall;
  bit          m_live;
  logic [63:0] exp_q[$];
  logic [63:0] word_ctr;
  bit          have_prev;
  bit          prev_hold;
  bit          prev_free;
  bit          prev_paused;
  logic [63:0] held_data;

  typedef struct {
    logic [15:0] msg;
    int          exp_len;
    logic        exp_sready;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_paused();
    return m_xoff || (m_pause_left > 0);
  endfunction

  function automatic void model_msg(input logic [15:0] msg);
    if (msg[15]) begin
      m_xoff = 1'b1;
      m_pause_left = 0;
    end else if (msg[7:0] == 8'd0) begin
      m_xoff = 1'b0;
      m_pause_left = 0;
    end else begin
      m_xoff = 1'b0;
      m_pause_left = int'(msg[7:0]);
    end
  endfunction

  // called at a sample point; checks outputs, advances one edge, updates the model
  task automatic cycle();
    bit mp, s_hs, m_hs, n_acc;
    mp = model_paused();
    chk("nfc_ready", nfc_ready, m_live);
    chk("paused", paused, mp);
    chk("stall_cycles", stall_cycles, m_stall);
    if (mp) chk("s_ready_paused", s_ready, 0);
    if (have_prev) begin
      if (prev_hold) begin
        chk("m_hold_valid", m_valid, 1);
        chk("m_hold_data", m_data, held_data);
      end
      if (prev_paused && prev_free) chk("no_beat_in_pause", m_valid, 0);
    end
    s_hs  = s_valid && s_ready;
    m_hs  = m_valid && m_ready;
    n_acc = nfc_valid && m_live;
    if (m_hs) begin
      chk("beat_pending", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) chk("m_data_order", m_data, exp_q.pop_front());
    end
    if (s_hs) begin
      exp_q.push_back(s_data);
      word_ctr = word_ctr + 1;
    end
    prev_hold   = m_valid && !m_ready;
    held_data   = m_data;
    prev_free   = !m_valid || m_hs;
    prev_paused = mp;
    have_prev   = 1'b1;
    @(posedge clk);
    #1;
    if (mp && m_stall != STAT_MAX) m_stall++;
    if (m_pause_left > 0) m_pause_left--;
    if (n_acc) model_msg(nfc_data);
    m_live = 1'b1;
    s_data = word_ctr;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    nfc_valid = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b0;
    #1;
    chk("rst_nfc_ready", nfc_ready, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_paused", paused, 0);
    chk("rst_stall", stall_cycles, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_live = 1'b0;
    m_pause_left = 0;
    m_xoff = 1'b0;
    m_stall = 0;
    exp_q.delete();
    have_prev = 1'b0;
    s_data = word_ctr;
    cycle();
    chk("rel_nfc_ready", nfc_ready, 1);
    chk("rel_s_ready", s_ready, 1);
    chk("rel_paused", paused, 0);
  endtask

  task automatic send(input logic [15:0] msg);
    nfc_valid = 1'b1;
    nfc_data  = msg;
    cycle();
    nfc_valid = 1'b0;
  endtask

  initial begin
    int cnt, sent, rcv, bubbles;
    bit started;
    rst_n = 1'b1;
    nfc_valid = 1'b0;
    nfc_data = 16'h0;
    s_valid = 1'b0;
    m_ready = 1'b0;
    word_ctr = 64'h0;
    s_data = 64'h0;
    m_live = 1'b0;
    m_pause_left = 0;
    m_xoff = 1'b0;
    m_stall = 0;
    #2;

    // decode table: message, paused cycles (LEN_BOUND = never resumed), s_ready afterwards
    vecs[0] = '{16'h0005, 5, 1'b1};
    vecs[1] = '{16'h0001, 1, 1'b1};
    vecs[2] = '{16'h00FF, 255, 1'b1};
    vecs[3] = '{16'h8000, LEN_BOUND, 1'b0};
    vecs[4] = '{16'h80FF, LEN_BOUND, 1'b0};
    vecs[5] = '{16'h7F03, 3, 1'b1};
    vecs[6] = '{16'h0000, 0, 1'b1};
    vecs[7] = '{16'h1200, 0, 1'b1};
    for (int i = 0; i < 8; i++) begin
      do_reset();
      send(vecs[i].msg);
      cnt = 0;
      while (paused && cnt < LEN_BOUND) begin
        cnt++;
        cycle();
      end
      chk($sformatf("vec%0d_len", i), cnt, vecs[i].exp_len);
      chk($sformatf("vec%0d_s_ready", i), s_ready, vecs[i].exp_sready);
      chk($sformatf("vec%0d_stall", i), stall_cycles, vecs[i].exp_len);
    end

    // free flow
    do_reset();
    word_ctr = 64'h0;
    s_data = word_ctr;
    m_ready = 1'b1;
    sent = 0; rcv = 0; bubbles = 0; started = 1'b0;
    for (int c = 0; c < 110; c++) begin
      s_valid = (sent < 100);
      if (c == 1) chk("ff_latency", m_valid, 1);
      if (m_valid) begin
        rcv++;
        started = 1'b1;
      end else if (started && rcv < 100) begin
        bubbles++;
      end
      if (s_valid && s_ready) sent++;
      cycle();
    end
    chk("ff_count", rcv, 100);
    chk("ff_bubbles", bubbles, 0);
    chk("ff_stall", stall_cycles, 0);

    // reload: 8 then 3 two cycles later
    do_reset();
    send(16'h0008);
    cycle();
    send(16'h0003);
    cnt = 0;
    while (paused && cnt < LEN_BOUND) begin
      cnt++;
      cycle();
    end
    chk("reload_len", cnt, 3);
    chk("reload_stall", stall_cycles, 5);

    // xoff/xon with traffic running
    do_reset();
    s_valid = 1'b1;
    m_ready = 1'b1;
    repeat (5) cycle();
    send(16'h8000);
    cnt = 0;
    for (int c = 0; c < 49; c++) begin
      if (paused) cnt++;
      cycle();
    end
    if (paused) cnt++;
    send(16'h0000);
    chk("xoff_len", cnt, 50);
    chk("xon_run", paused, 0);
    chk("xon_stall", stall_cycles, 50);
    s_valid = 1'b0;
    repeat (6) cycle();
    chk("xon_drained", exp_q.size(), 0);

    // backpressure with xoff arriving alongside the second beat
    do_reset();
    word_ctr = 64'hD000;
    s_data = word_ctr;
    s_valid = 1'b1;
    m_ready = 1'b0;
    cycle();
    chk("bp_d0_valid", m_valid, 1);
    chk("bp_d0_data", m_data, 64'hD000);
    nfc_valid = 1'b1;
    nfc_data = 16'h8000;
    cycle();
    nfc_valid = 1'b0;
    s_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk("bp_d0_stable", m_data, 64'hD000);
      cycle();
    end
    m_ready = 1'b1;
    cycle();
    for (int c = 0; c < 5; c++) begin
      chk("bp_d1_withheld", m_valid, 0);
      cycle();
    end
    send(16'h0000);
    cycle();
    chk("bp_d1_valid", m_valid, 1);
    chk("bp_d1_data", m_data, 64'hD001);
    repeat (2) cycle();

    // reset in the middle of a long pause with beats buffered
    do_reset();
    s_valid = 1'b1;
    m_ready = 1'b0;
    send(16'h00FF);
    repeat (9) cycle();
    chk("mid_paused", paused, 1);
    do_reset();
    cycle();
    chk("mid_skid_gone", m_valid, 0);

    // stall counter saturation
    do_reset();
    send(16'h8000);
    repeat (1030) cycle();
    chk("stall_sat", stall_cycles, STAT_MAX);
    send(16'h0000);

    // random traffic and NFC messages against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      s_valid = ($urandom_range(0, 3) != 0);
      m_ready = ($urandom_range(0, 3) != 0);
      nfc_valid = ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 3))
        0: nfc_data = 16'h8000 | 16'($urandom_range(0, 16'h7FFF));
        1: nfc_data = 16'($urandom_range(0, 127)) << 8;
        default: nfc_data = 16'($urandom_range(1, 30)) | (16'($urandom_range(0, 127)) << 8);
      endcase
      cycle();
    end
    nfc_valid = 1'b0;
    s_valid = 1'b0;
    send(16'h0000);
    m_ready = 1'b1;
    repeat (10) cycle();
    chk("rand_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
